// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous SRAM between the core and
// a debug/loader port. Every access walks IDLE -> ISSUE -> RESP -> IDLE, ties
// are broken round-robin, and ready/rdata are registered so that a request
// seen in IDLE at edge N is answered by a ready pulse after edge N+2.
// Optional feature: define DMEM_ARB_LED_EN to decode LED_ADDR as a 6-bit
// active-low LED register instead of an SRAM word.
module dmem_arbiter #(
    parameter logic [31:0] LED_ADDR = 32'd8,
    parameter int          AD_W     = 8
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [31:0]     core_addr,
    input  logic [31:0]     core_wdata,
    output logic [31:0]     core_rdata,
    output logic            core_ready,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [31:0]     dbg_addr,
    input  logic [31:0]     dbg_wdata,
    output logic [31:0]     dbg_rdata,
    output logic            dbg_ready,
    output logic [AD_W-1:0] mem_ad,
    output logic [31:0]     mem_din,
    output logic            mem_wre,
    input  logic [31:0]     mem_dout,
    output logic [5:0]      led
);

`ifdef DMEM_ARB_LED_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    // last_grant / grant_dbg: 1 means the debug port, 0 means the core.
    logic        last_grant;
    logic        grant_dbg;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        take;
    logic        pick_dbg;
    logic        led_hit;
    logic [31:0] resp_data;

    // Next-state and arbitration: in IDLE pick a single requester, or on a tie
    // the one that was not granted last time.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        pick_dbg   = 1'b0;
        case (state)
            IDLE: begin
                if (core_req && dbg_req) begin
                    take     = 1'b1;
                    pick_dbg = ~last_grant;
                end else if (core_req) begin
                    take     = 1'b1;
                    pick_dbg = 1'b0;
                end else if (dbg_req) begin
                    take     = 1'b1;
                    pick_dbg = 1'b1;
                end
                if (take) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winner's request and remember who won for the next tie.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant <= 1'b1;
            grant_dbg  <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else if (take) begin
            last_grant <= pick_dbg;
            grant_dbg  <= pick_dbg;
            lat_we     <= pick_dbg ? dbg_we    : core_we;
            lat_addr   <= pick_dbg ? dbg_addr  : core_addr;
            lat_wdata  <= pick_dbg ? dbg_wdata : core_wdata;
        end
    end

    // The LED decode compares the full byte address; it is forced off when the
    // feature is not built, leaving LED_ADDR an ordinary SRAM word.
    assign led_hit = LED_EN && (lat_addr == LED_ADDR);

    // SRAM drive: word address wraps (byte offset and high bits dropped), and
    // the write strobe is only raised in ISSUE for a non-LED write.
    assign mem_ad  = lat_addr[AD_W+1:2];
    assign mem_din = lat_wdata;
    assign mem_wre = (state == ISSUE) && lat_we && !led_hit;

    // Response value: writes return zero, LED reads return the uninverted LED
    // pattern, everything else returns the SRAM output.
    always_comb begin
        resp_data = 32'd0;
        if (!lat_we) begin
            if (led_hit) begin
                resp_data = {26'd0, ~led};
            end else begin
                resp_data = mem_dout;
            end
        end
    end

    // Registered one-cycle ready pulse and sticky read data for the winner.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            core_ready <= 1'b0;
            dbg_ready  <= 1'b0;
            core_rdata <= 32'd0;
            dbg_rdata  <= 32'd0;
        end else begin
            core_ready <= 1'b0;
            dbg_ready  <= 1'b0;
            if (state == RESP) begin
                if (grant_dbg) begin
                    dbg_ready <= 1'b1;
                    dbg_rdata <= resp_data;
                end else begin
                    core_ready <= 1'b1;
                    core_rdata <= resp_data;
                end
            end
        end
    end

    // LED register, active-low; only an LED write in ISSUE changes it.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= 6'h3F;
        end else if ((state == ISSUE) && lat_we && led_hit) begin
            led <= ~lat_wdata[5:0];
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and randomized checks of dmem_arbiter against
// a transaction-level model (word-indexed memory array, LED value, tie owner).
module tb_dmem_arbiter;

    localparam int          AD_W     = 8;
    localparam logic [31:0] LED_ADDR = 32'd8;
`ifdef DMEM_ARB_LED_EN
    localparam logic [5:0]  LED_AFTER = 6'h15;
    localparam logic [31:0] WORD2_AFTER = 32'd0;
`else
    localparam logic [5:0]  LED_AFTER = 6'h3F;
    localparam logic [31:0] WORD2_AFTER = 32'h2A;
`endif

    logic            clk = 1'b0;
    logic            sys_rst_n;
    logic            core_req, core_we;
    logic [31:0]     core_addr, core_wdata, core_rdata;
    logic            core_ready;
    logic            dbg_req, dbg_we;
    logic [31:0]     dbg_addr, dbg_wdata, dbg_rdata;
    logic            dbg_ready;
    logic [AD_W-1:0] mem_ad;
    logic [31:0]     mem_din;
    logic            mem_wre;
    logic [31:0]     mem_dout;
    logic [5:0]      led;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.LED_ADDR(LED_ADDR), .AD_W(AD_W)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_wre(mem_wre),
        .mem_dout(mem_dout), .led(led)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [31:0] sram [0:255] = '{default: 32'd0};
    always @(posedge clk) begin
        if (mem_wre) sram[mem_ad] <= mem_din;
        mem_dout <= sram[mem_ad];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    logic [5:0]  ref_led;
    bit          ref_last;

    typedef struct {
        bit          src;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_led;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_led(input logic [31:0] a);
`ifdef DMEM_ARB_LED_EN
        return a == LED_ADDR;
`else
        return (a == LED_ADDR) && 1'b0;
`endif
    endfunction

    task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp);
        exp = 32'd0;
        if (we) begin
            if (is_led(a)) ref_led = ~d[5:0];
            else ref_mem[a[9:2]] = d;
        end else begin
            if (is_led(a)) exp = {26'd0, ~ref_led};
            else exp = ref_mem[a[9:2]];
        end
    endtask

    task automatic drive(input bit src, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (!src) begin
            core_req = req; core_we = we; core_addr = a; core_wdata = d;
        end else begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end
    endtask

    function automatic logic rdy(input bit src);
        return src ? dbg_ready : core_ready;
    endfunction

    function automatic logic [31:0] rdat(input bit src);
        return src ? dbg_rdata : core_rdata;
    endfunction

    // One isolated access, called on a negedge with the arbiter idle.
    task automatic apply_stimulus(input bit src, input bit we, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] exp_rdata,
                                  input logic [5:0] exp_led, input string name);
        int seen;
        seen = 0;
        drive(src, 1'b1, we, a, d);
        for (int k = 1; k <= 8 && seen == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_output({name, "_wre"}, 32'(mem_wre), 32'(we && !is_led(a)));
                check_output({name, "_ad"}, 32'(mem_ad), 32'(a[9:2]));
            end
            if (k == 2 && mem_wre) check_output({name, "_wre2"}, 32'(mem_wre), 32'd0);
            if (rdy(!src)) check_output({name, "_other_rdy"}, 32'(rdy(!src)), 32'd0);
            if (rdy(src)) seen = k;
        end
        check_output({name, "_lat"}, 32'(seen), 32'd3);
        check_output({name, "_rdata"}, rdat(src), exp_rdata);
        check_output({name, "_led"}, 32'(led), 32'(exp_led));
        drive(src, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFF_FC00);
        return a;
    endfunction

    vec_t vecs [10];

    initial begin
        logic [31:0] expv;
        logic [31:0] ops_addr [2][2];
        logic [31:0] ops_data [2][2];
        bit          ops_we   [2][2];
        logic [31:0] ops_exp  [2][2];
        int          opi [2];
        int          n;
        bit          pend [2];
        bit          waiting [2];
        bit          p_we [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wdata [2];
        bit          win;
        int          seen;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        ref_led  = 6'h3F;
        ref_last = 1'b1;

        sys_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_core_ready", 32'(core_ready), 32'd0);
        check_output("rst_dbg_ready", 32'(dbg_ready), 32'd0);
        check_output("rst_core_rdata", core_rdata, 32'd0);
        check_output("rst_dbg_rdata", dbg_rdata, 32'd0);
        check_output("rst_led", 32'(led), 32'h3F);
        check_output("rst_wre", 32'(mem_wre), 32'd0);
        check_output("rst_ad", 32'(mem_ad), 32'd0);

        // Both ports request in the same cycle and keep requesting.
        ops_we[0][0] = 1; ops_addr[0][0] = 32'h40; ops_data[0][0] = 32'h11; ops_exp[0][0] = 0;
        ops_we[0][1] = 0; ops_addr[0][1] = 32'h44; ops_data[0][1] = 32'h0;  ops_exp[0][1] = 32'h22;
        ops_we[1][0] = 1; ops_addr[1][0] = 32'h44; ops_data[1][0] = 32'h22; ops_exp[1][0] = 0;
        ops_we[1][1] = 0; ops_addr[1][1] = 32'h40; ops_data[1][1] = 32'h0;  ops_exp[1][1] = 32'h11;
        opi[0] = 0; opi[1] = 0; n = 0;
        drive(1'b0, 1'b1, ops_we[0][0], ops_addr[0][0], ops_data[0][0]);
        drive(1'b1, 1'b1, ops_we[1][0], ops_addr[1][0], ops_data[1][0]);
        for (int k = 1; k <= 20 && n < 4; k++) begin
            @(negedge clk);
            if (core_ready && dbg_ready) check_output("tie_both_ready", 32'd1, 32'd0);
            if (core_ready || dbg_ready) begin
                win = dbg_ready;
                check_output("tie_order", 32'(win), 32'(n % 2));
                check_output("tie_cycle", 32'(k), 32'(3 * (n + 1)));
                check_output("tie_rdata", rdat(win), ops_exp[win][opi[win]]);
                opi[win]++;
                if (opi[win] == 2) drive(win, 1'b0, 1'b0, 32'd0, 32'd0);
                else drive(win, 1'b1, ops_we[win][1], ops_addr[win][1], ops_data[win][1]);
                n++;
            end
        end
        check_output("tie_count", 32'(n), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        ref_mem[16] = 32'h11;
        ref_mem[17] = 32'h22;
        ref_last    = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        6'h3F};
        vecs[1] = '{0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 6'h3F};
        vecs[2] = '{1, 1, 32'h400, 32'h5,        32'h0,        6'h3F};
        vecs[3] = '{0, 0, 32'h0,   32'h0,        32'h5,        6'h3F};
        vecs[4] = '{1, 0, 32'h13,  32'h0,        32'hDEADBEEF, 6'h3F};
        vecs[5] = '{0, 1, 32'h8,   32'h2A,       32'h0,        LED_AFTER};
        vecs[6] = '{0, 0, 32'h8,   32'h0,        32'h2A,       LED_AFTER};
        vecs[7] = '{1, 1, 32'hFFC, 32'h12345678, 32'h0,        LED_AFTER};
        vecs[8] = '{0, 0, 32'h3FC, 32'h0,        32'h12345678, LED_AFTER};
        vecs[9] = '{1, 0, 32'h44,  32'h0,        32'h22,       LED_AFTER};
        for (int i = 0; i < 10; i++) begin
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, expv);
            apply_stimulus(vecs[i].src, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                           vecs[i].exp_rdata, vecs[i].exp_led, $sformatf("vec%0d", i));
            ref_last = vecs[i].src;
            @(negedge clk);
        end
        check_output("sram_word2", sram[2], WORD2_AFTER);
        repeat (3) @(negedge clk);
        check_output("core_rdata_hold", core_rdata, 32'h12345678);
        check_output("dbg_rdata_hold", dbg_rdata, 32'h22);

        // Randomized traffic: the model predicts the winner of each slot.
        pend[0] = 0; pend[1] = 0; waiting[0] = 0; waiting[1] = 0;
        for (int s = 0; s < 150; s++) begin
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && waiting[r] && $urandom_range(0, 9) == 0) begin
                    pend[r] = 0;
                    waiting[r] = 0;
                    drive(r[0], 1'b0, 1'b0, 32'd0, 32'd0);
                end
                if (!pend[r] && $urandom_range(0, 9) < 6) begin
                    pend[r]    = 1;
                    p_we[r]    = ($urandom_range(0, 1) == 1);
                    p_addr[r]  = rand_addr();
                    p_wdata[r] = $urandom;
                end
            end
            if (!pend[0] && !pend[1]) begin
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                @(negedge clk);
                continue;
            end
            for (int r = 0; r < 2; r++) begin
                if (pend[r]) drive(r[0], 1'b1, p_we[r], p_addr[r], p_wdata[r]);
                else drive(r[0], 1'b0, 1'b0, 32'd0, 32'd0);
            end
            win = (pend[0] && pend[1]) ? !ref_last : pend[1];
            model_access(p_we[win], p_addr[win], p_wdata[win], expv);
            ref_last = win;
            seen = 0;
            for (int k = 1; k <= 8 && seen == 0; k++) begin
                @(negedge clk);
                if (rdy(!win)) check_output("rnd_wrong_ready", 32'(rdy(!win)), 32'd0);
                if (rdy(win)) seen = k;
            end
            check_output("rnd_lat", 32'(seen), 32'd3);
            check_output("rnd_rdata", rdat(win), expv);
            check_output("rnd_led", 32'(led), 32'(ref_led));
            pend[win] = 0;
            waiting[win] = 0;
            if (pend[!win]) waiting[!win] = 1;
            drive(win, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);

        // Reset in the ISSUE cycle of a write aborts it.
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        check_output("abort_wre_before", 32'(mem_wre), 32'd1);
        #1 sys_rst_n = 1'b0;
        #1;
        check_output("abort_wre_async", 32'(mem_wre), 32'd0);
        check_output("abort_led", 32'(led), 32'h3F);
        check_output("abort_core_rdata", core_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        ref_led  = 6'h3F;
        ref_last = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (core_ready || dbg_ready) n++;
        end
        check_output("abort_no_ready", 32'(n), 32'd0);
        model_access(1'b0, 32'h20, 32'd0, expv);
        apply_stimulus(1'b0, 1'b0, 32'h20, 32'd0, expv, 6'h3F, "abort_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
